// File: rtl/step_shaper.sv
// Shapes stepgen STP/DIR into driver-safe pulses with guaranteed high/low time and DIR setup/hold.
// Steps that arrive faster than the driver timing allows are queued in a signed pending counter.
module step_shaper #(
    parameter int PULSE_LEN = 96,
    parameter int SPACE_LEN = 96,
    parameter int DIR_SETUP = 240,
    parameter int DIR_HOLD  = 96,
    parameter int PEND_BITS = 8
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        enable,
    input  logic                        stp_in,
    input  logic                        dir_in,
    output logic                        stp_out,
    output logic                        dir_out,
    output logic                        busy,
    output logic                        overflow,
    output logic signed [PEND_BITS-1:0] pending
);

    localparam int CNT_MAX_PS = (PULSE_LEN > SPACE_LEN) ? PULSE_LEN : SPACE_LEN;
    localparam int CNT_MAX    = (CNT_MAX_PS > DIR_SETUP) ? CNT_MAX_PS : DIR_SETUP;
    localparam int CNT_W      = $clog2(CNT_MAX + 1);
    localparam int SUM_W      = PEND_BITS + 2;
    localparam logic signed [SUM_W-1:0]     PEND_MAX  = SUM_W'((2 ** (PEND_BITS - 1)) - 1);
    localparam logic signed [PEND_BITS-1:0] PEND_ZERO = '0;

    if (PULSE_LEN < 1 || SPACE_LEN < 1 || DIR_SETUP < 1 || DIR_HOLD > SPACE_LEN) begin : g_param_check
        $error("step_shaper: invalid timing parameters");
    end

    typedef enum logic [1:0] {S_IDLE, S_SETUP, S_HIGH, S_LOW} state_t;

    state_t                  state;
    logic [CNT_W-1:0]        cnt;
    logic                    stp_prev;
    logic                    primed;

    logic                    rise;
    logic                    pend_nz;
    logic                    want_dir;
    logic                    decide;
    logic                    start;
    logic signed [1:0]       inc;
    logic signed [1:0]       dec;
    logic signed [SUM_W-1:0] pend_w;
    logic signed [SUM_W-1:0] inc_w;
    logic signed [SUM_W-1:0] dec_w;
    logic signed [SUM_W-1:0] sum_noinc;
    logic signed [SUM_W-1:0] sum_inc;

    // Symmetric range: the most negative code is never used.
    function automatic logic fits(input logic signed [SUM_W-1:0] v);
        return (v <= PEND_MAX) && (v >= -PEND_MAX);
    endfunction

    function automatic logic signed [1:0] sign_of(input logic signed [PEND_BITS-1:0] v);
        if (v > PEND_ZERO)
            return 2'sd1;
        else if (v < PEND_ZERO)
            return -2'sd1;
        else
            return 2'sd0;
    endfunction

    always_comb begin
        rise     = primed & stp_in & ~stp_prev;
        pend_nz  = (pending != PEND_ZERO);
        want_dir = (pending > PEND_ZERO);
        decide   = (state == S_IDLE) || (state == S_LOW && cnt == '0);
        start    = pend_nz && (want_dir == dir_out) &&
                   (decide || (state == S_SETUP && cnt == '0));
        inc = 2'sd0;
        if (rise && enable)
            inc = dir_in ? 2'sd1 : -2'sd1;
        dec       = start ? sign_of(pending) : 2'sd0;
        pend_w    = {{2{pending[PEND_BITS-1]}}, pending};
        inc_w     = {{PEND_BITS{inc[1]}}, inc};
        dec_w     = {{PEND_BITS{dec[1]}}, dec};
        sum_noinc = pend_w - dec_w;
        sum_inc   = sum_noinc + inc_w;
    end

    assign busy = (state != S_IDLE) || pend_nz;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stp_prev <= 1'b0;
            primed   <= 1'b0;
        end else begin
            stp_prev <= stp_in;
            primed   <= 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pending  <= '0;
            overflow <= 1'b0;
        end else if (!enable) begin
            pending  <= '0;
            overflow <= 1'b0;
        end else if (fits(sum_inc)) begin
            pending  <= sum_inc[PEND_BITS-1:0];
        end else begin
            pending  <= sum_noinc[PEND_BITS-1:0];
            overflow <= 1'b1;
        end
    end

    // The end of LOW takes the same decision as IDLE so back-to-back pulses lose no cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= S_IDLE;
            cnt     <= '0;
            stp_out <= 1'b0;
            dir_out <= 1'b0;
        end else if (decide) begin
            if (!pend_nz) begin
                state <= S_IDLE;
            end else if (want_dir == dir_out) begin
                state   <= S_HIGH;
                stp_out <= 1'b1;
                cnt     <= CNT_W'(PULSE_LEN - 1);
            end else begin
                state   <= S_SETUP;
                dir_out <= want_dir;
                cnt     <= CNT_W'(DIR_SETUP - 1);
            end
        end else if (cnt != '0) begin
            cnt <= cnt - 1'b1;
        end else begin
            case (state)
                S_SETUP: begin
                    if (start) begin
                        state   <= S_HIGH;
                        stp_out <= 1'b1;
                        cnt     <= CNT_W'(PULSE_LEN - 1);
                    end else begin
                        state <= S_IDLE;
                    end
                end
                S_HIGH: begin
                    state   <= S_LOW;
                    stp_out <= 1'b0;
                    cnt     <= CNT_W'(SPACE_LEN - 1);
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_step_shaper.sv
// Scoreboard bench for step_shaper: stimulus pushes expected pulses, a monitor pops and compares them.
module tb_step_shaper;

    localparam int PULSE = 96;
    localparam int SPACE = 96;
    localparam int SETUP = 240;
    localparam int HOLD  = 96;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic enable = 1'b1;
    logic stp_in = 1'b0;
    logic dir_in = 1'b0;
    logic stp4 = 1'b0;
    logic dir4 = 1'b0;

    logic              stp_out, dir_out, busy, overflow;
    logic signed [7:0] pending;
    logic              stp_out4, dir_out4, busy4, ovf4;
    logic signed [3:0] pending4;

    step_shaper #(.PULSE_LEN(PULSE), .SPACE_LEN(SPACE), .DIR_SETUP(SETUP),
                  .DIR_HOLD(HOLD), .PEND_BITS(8)) dut (
        .clk(clk), .rst(rst), .enable(enable), .stp_in(stp_in), .dir_in(dir_in),
        .stp_out(stp_out), .dir_out(dir_out), .busy(busy), .overflow(overflow),
        .pending(pending));

    step_shaper #(.PULSE_LEN(PULSE), .SPACE_LEN(SPACE), .DIR_SETUP(SETUP),
                  .DIR_HOLD(HOLD), .PEND_BITS(4)) dut4 (
        .clk(clk), .rst(rst), .enable(enable), .stp_in(stp4), .dir_in(dir4),
        .stp_out(stp_out4), .dir_out(dir_out4), .busy(busy4), .overflow(ovf4),
        .pending(pending4));

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int vectors = 0;
    int errors  = 0;

    typedef struct {
        int   chan;
        int   cyc;
        logic dir;
    } exp_t;
    exp_t exp_q[$];

    task automatic check(input string name, input int act, input int want);
        vectors++;
        if (act !== want) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, want, cyc);
        end
    endtask

    task automatic push(input int c, input int at, input logic d);
        exp_t e;
        e.chan = c;
        e.cyc  = at;
        e.dir  = d;
        exp_q.push_back(e);
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic tick_to(input int t);
        while (cyc < t) tick(1);
    endtask

    task automatic do_reset;
        rst = 1'b1;
        tick(3);
        rst = 1'b0;
        tick(2);
    endtask

    // Monitor: pulse rise time/dir against the scoreboard, high width, dir hold after a fall.
    logic ps[2];
    logic pd[2];
    int   rise_c[2];
    int   fall_c[2];
    logic ms, md;
    exp_t me;

    initial begin
        for (int c = 0; c < 2; c++) begin
            ps[c] = 1'b0;
            pd[c] = 1'b0;
            rise_c[c] = 0;
            fall_c[c] = -100000;
        end
        forever begin
            @(negedge clk);
            for (int c = 0; c < 2; c++) begin
                ms = (c == 0) ? stp_out : stp_out4;
                md = (c == 0) ? dir_out : dir_out4;
                if (!rst) begin
                    if (ms && !ps[c]) begin
                        if (exp_q.size() == 0) begin
                            vectors++;
                            errors++;
                            $display("FAIL unexpected_pulse: chan %0d rose at cycle %0d, expected none", c, cyc);
                        end else begin
                            me = exp_q.pop_front();
                            check("pulse_chan", c, me.chan);
                            check("pulse_cycle", cyc, me.cyc);
                            check("pulse_dir", int'(md), int'(me.dir));
                        end
                        rise_c[c] = cyc;
                    end
                    if (!ms && ps[c]) begin
                        check("high_width", cyc - rise_c[c], PULSE);
                        fall_c[c] = cyc;
                    end
                    if (md != pd[c]) begin
                        vectors++;
                        if (cyc - fall_c[c] < HOLD) begin
                            errors++;
                            $display("FAIL dir_hold: chan %0d dir changed %0d cycles after fall, expected >= %0d",
                                     c, cyc - fall_c[c], HOLD);
                        end
                    end
                end
                ps[c] = ms;
                pd[c] = md;
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation exceeded time limit at cycle %0d, expected completion", cyc);
        $fatal(1, "watchdog");
    end

    int n;
    int m;

    initial begin
        // Reset state
        tick(1);
        check("rst_stp_out", int'(stp_out), 0);
        check("rst_dir_out", int'(dir_out), 0);
        check("rst_pending", int'(pending), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_overflow", int'(overflow), 0);
        do_reset;

        // Single step, direction already matching
        n = cyc;
        stp_in = 1'b1;
        dir_in = 1'b0;
        push(0, n + 2, 1'b0);
        tick(1);
        stp_in = 1'b0;
        check("t1_pending_inc", int'(pending), -1);
        tick(1);
        check("t1_pending_dec", int'(pending), 0);
        tick_to(n + 193);
        check("t1_busy_low_phase", int'(busy), 1);
        tick(1);
        check("t1_busy_done", int'(busy), 0);

        // Single step with direction change
        do_reset;
        n = cyc;
        stp_in = 1'b1;
        dir_in = 1'b1;
        push(0, n + 2 + SETUP, 1'b1);
        tick(1);
        stp_in = 1'b0;
        check("t2_dir_before", int'(dir_out), 0);
        tick(1);
        check("t2_dir_after", int'(dir_out), 1);
        tick_to(n + 241);
        check("t2_no_early_pulse", int'(stp_out), 0);
        tick_to(n + 242 + 192 + 5);
        check("t2_dir_kept", int'(dir_out), 1);
        check("t2_busy_done", int'(busy), 0);

        // Ten steps, four cycles apart
        do_reset;
        n = cyc;
        for (int k = 0; k < 10; k++) push(0, n + 242 + 192 * k, 1'b1);
        for (int i = 0; i < 10; i++) begin
            stp_in = 1'b1;
            dir_in = 1'b1;
            tick(2);
            stp_in = 1'b0;
            tick(2);
        end
        check("t3_pending_peak", int'(pending), 10);
        tick_to(n + 242 + 192 * 10 + 5);
        check("t3_pending_final", int'(pending), 0);
        check("t3_overflow", int'(overflow), 0);
        check("t3_busy_done", int'(busy), 0);

        // Saturation on the 4-bit instance
        do_reset;
        n = cyc;
        for (int k = 0; k < 7; k++) push(1, n + 242 + 192 * k, 1'b1);
        for (int i = 0; i < 9; i++) begin
            stp4 = 1'b1;
            dir4 = 1'b1;
            tick(1);
            stp4 = 1'b0;
            tick(1);
        end
        check("t4_pending_sat", int'(pending4), 7);
        check("t4_overflow_set", int'(ovf4), 1);
        tick_to(n + 242 + 192 * 7 + 5);
        check("t4_overflow_sticky", int'(ovf4), 1);
        check("t4_pending_final", int'(pending4), 0);
        enable = 1'b0;
        tick(1);
        check("t4_overflow_cleared", int'(ovf4), 0);
        enable = 1'b1;

        // +3 then -5 before emission
        do_reset;
        n = cyc;
        for (int i = 0; i < 8; i++) begin
            stp_in = 1'b1;
            dir_in = (i < 3);
            tick(1);
            stp_in = 1'b0;
            tick(1);
        end
        check("t5_pending_net", int'(pending), -2);
        check("t5_dir_first_setup", int'(dir_out), 1);
        push(0, n + 483, 1'b0);
        push(0, n + 675, 1'b0);
        tick_to(n + 244);
        check("t5_dir_reversed", int'(dir_out), 0);
        tick_to(n + 675 + 192 + 5);
        check("t5_dir_final", int'(dir_out), 0);
        check("t5_pending_final", int'(pending), 0);

        // Async reset mid-pulse, stp_in held high across release
        do_reset;
        n = cyc;
        stp_in = 1'b1;
        dir_in = 1'b0;
        push(0, n + 2, 1'b0);
        tick_to(n + 42);
        check("t6_mid_pulse_high", int'(stp_out), 1);
        rst = 1'b1;
        #1;
        check("t6_async_drop", int'(stp_out), 0);
        tick(3);
        rst = 1'b0;
        tick(300);
        check("t6_held_pending", int'(pending), 0);
        check("t6_held_busy", int'(busy), 0);

        // Disable mid-pulse: pulse completes, queued step is flushed
        stp_in = 1'b0;
        tick(2);
        m = cyc;
        stp_in = 1'b1;
        dir_in = 1'b0;
        push(0, m + 2, 1'b0);
        tick(1);
        stp_in = 1'b0;
        tick(3);
        stp_in = 1'b1;
        tick(1);
        stp_in = 1'b0;
        check("t6_second_queued", int'(pending), -1);
        tick_to(m + 20);
        enable = 1'b0;
        tick(1);
        check("t6_flush_pending", int'(pending), 0);
        check("t6_pulse_continues", int'(stp_out), 1);
        tick_to(m + 2 + 192 + 300);
        enable = 1'b1;
        check("t6_final_pending", int'(pending), 0);
        check("t6_final_busy", int'(busy), 0);

        check("all_pulses_seen", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule

// File: doc/step_shaper.md
Name: step_shaper

Overview:
- Sits directly downstream of a stepgen instance, between its STP/DIR outputs and the board's STP/DIR pins.
- Converts each stepgen rising step edge into a driver-safe pulse with guaranteed minimum high time, low time, and DIR setup/hold.
- Buffers steps in a signed pending counter, so steps arriving faster than the driver timing allows are delayed rather than lost.
- One instance per joint.

Parameters:
- PULSE_LEN, 96: stp_out high time in clk cycles (2 us at 48 MHz); must be >=1.
- SPACE_LEN, 96: minimum stp_out low time after each pulse, in clk cycles; must be >=1.
- DIR_SETUP, 240: cycles dir_out must be stable before a stp_out rising edge (5 us); must be >=1.
- DIR_HOLD, 96: cycles dir_out must be stable after a stp_out falling edge; must be <=SPACE_LEN (elaboration-time check).
- PEND_BITS, 8: width of the signed pending-step counter.

Ports:
- clk  in  1  system clock (sysclk)
- rst  in  1  asynchronous, active-high reset
- enable  in  1  joint enable (jointEnableN); low flushes pending steps
- stp_in  in  1  step from stepgen; each 0->1 transition is one step
- dir_in  in  1  direction from stepgen; 1 = positive, sampled with the stp_in rising edge
- stp_out  out  1  shaped step to pin
- dir_out  out  1  shaped direction to pin
- busy  out  1  high when FSM is not IDLE or pending != 0
- overflow  out  1  sticky; a step was dropped at counter saturation
- pending  out  PEND_BITS  signed pending step count, for debug

Behaviour:
Reset (async, rst high):
- stp_out=0, dir_out=0, pending=0, overflow=0, busy=0, FSM=IDLE, stp_prev=0, primed=0.
- stp_out drops immediately, even mid-pulse.

Edge detect:
- stp_in and dir_in are in the clk domain; no synchroniser.
- stp_prev <= stp_in every cycle.
- primed sets on the first clk after reset. No edge is counted while primed=0, so a stp_in that is already high at reset release is not counted.
- rise = primed & stp_in & ~stp_prev.

Pending counter update each cycle: pending <= pending + inc - dec.
- inc is +1 (dir_in=1) or -1 (dir_in=0) when rise & enable; otherwise 0.
- dec is sign(pending) when the FSM enters HIGH; otherwise 0.
- Simultaneous inc and dec in one cycle are both applied.
- If the result would exceed +(2^(PEND_BITS-1)-1) or fall below -(2^(PEND_BITS-1)-1), inc is discarded and overflow sets. Overflow clears only on rst or enable=0.

Disable:
- enable=0 forces pending to 0 and clears overflow.
- A pulse in progress completes its full HIGH and LOW phases; the FSM then returns to IDLE.
- Rises while enable=0 are ignored.

FSM (registered outputs):
- IDLE:
  - pending=0: stay.
  - pending!=0 and want_dir (pending>0) equals dir_out: enter HIGH, stp_out<=1, dec applied.
  - Otherwise: dir_out<=want_dir, counter<=DIR_SETUP-1, enter SETUP.
- SETUP: count down. At 0:
  - pending!=0 with matching dir: enter HIGH.
  - Otherwise (pending went to 0 or flipped sign): IDLE.
- HIGH: stp_out=1 for exactly PULSE_LEN cycles, then stp_out<=0 and enter LOW.
- LOW: stp_out=0 for exactly SPACE_LEN cycles, then IDLE. The IDLE decision happens in that same cycle, so back-to-back pulses have period PULSE_LEN+SPACE_LEN.
- dir_out changes only on the IDLE->SETUP transition. Hold is therefore >=SPACE_LEN>=DIR_HOLD.

Timing:
- Latency: rise sampled at edge N; pending updates at N+1; stp_out rises at edge N+2 when IDLE with matching dir_out.
- With a direction change, stp_out rises at edge N+2+DIR_SETUP.

busy = (state!=IDLE) | (pending!=0).

Test Plan:
- Reset with defaults, dir_out=0, single stp_in 0->1 with dir_in=0 at edge 10 -> dir_out->1? No: dir_in=0 matches dir_out=0; stp_out high at edge 12 through edge 107 (96 cycles), low >=96; pending returns to 0; busy low at edge 204.
- From reset, stp_in rise with dir_in=1 at edge 10 -> dir_out=1 at edge 12; stp_out rises at edge 252 (DIR_SETUP=240); dir_out unchanged until at least 96 cycles after stp_out falls.
- 10 stp_in rises 4 cycles apart, dir_in=1 -> pending peaks at 10 minus emitted; exactly 10 stp_out pulses, each 96 high / 96 low; final pending 0; overflow 0.
- PEND_BITS=4, 9 rises in 9 consecutive-edge bursts (alternating stp_in) while the FSM is in SETUP -> pending saturates at 7; overflow=1; exactly 7 pulses emitted; enable=0 clears overflow.
- Rises: +3 steps, then -5 steps before any emission -> pending=-2; dir_out ends 0; exactly 2 pulses emitted after the DIR_SETUP wait; no pulse emitted with wrong dir.
- Assert rst 40 cycles into HIGH -> stp_out=0 in the same cycle (async); after release, stp_in held high produces no pulse; enable=0 mid-pulse -> pulse completes its full 96-cycle high time, pending=0, no further pulses.
